// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD display path: active-low segment codes
// in {g,f,e,d,c,b,a} order and a helper that flags non-decimal digits.
package bcd_disp_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_DASH  = 7'b0111111;

    // Codes for nibble values 0..15. Values 10..15 are not decimal, so they
    // show a dash to make a corrupted converter word visible on the panel.
    localparam seg_t SEG_TABLE [16] = '{
        7'b1000000, // 0
        7'b1111001, // 1
        7'b0100100, // 2
        7'b0110000, // 3
        7'b0011001, // 4
        7'b0010010, // 5
        7'b0000010, // 6
        7'b1111000, // 7
        7'b0000000, // 8
        7'b0010000, // 9
        SEG_DASH,   // 10
        SEG_DASH,   // 11
        SEG_DASH,   // 12
        SEG_DASH,   // 13
        SEG_DASH,   // 14
        SEG_DASH    // 15
    };

    // True when a BCD nibble holds a value the converter should never emit.
    function automatic logic is_bad_digit(input logic [3:0] digit);
        return (digit > 4'd9);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit decoder: one BCD nibble plus a blank request to an
// active-low 7-segment pattern. Blank overrides the digit value.
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] i_Digit,
    input  logic       i_Blank,
    output logic [6:0] o_Segment
);

    // Blank wins over the table lookup; dashes for 10..15 come from the table.
    always_comb begin
        if (i_Blank) begin
            o_Segment = SEG_BLANK;
        end else begin
            o_Segment = SEG_TABLE[i_Digit];
        end
    end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Multiplexed common-anode 7-segment driver. Captures a packed BCD word on
// its done strobe, holds it as pending and only promotes it to the shown
// word when the scan wraps back to digit 0, so a frame never mixes words.
// Each digit slot opens with a short all-off window against ghosting.
module bcd_seg7_scan
    import bcd_disp_pkg::*;
#(
    parameter int DECIMAL_DIGITS = 4,
    parameter int REFRESH_DIV    = 100000,
    parameter int BLANK_CYC      = 1000,
    parameter int DP_POS         = 3
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset_n,
    input  logic [DECIMAL_DIGITS*4-1:0]   i_BCD,
    input  logic                          i_DV,
    input  logic                          i_Enable,
    output logic [DECIMAL_DIGITS-1:0]     o_Anode,
    output logic [6:0]                    o_Segment,
    output logic                          o_DP,
    output logic                          o_Invalid,
    output logic                          o_Frame
);

    localparam int BCD_W   = DECIMAL_DIGITS * 4;
    localparam int PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DIG_W   = $clog2(DECIMAL_DIGITS);

    localparam logic [PRESC_W-1:0]        PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [PRESC_W-1:0]        PRESC_LIT  = PRESC_W'(BLANK_CYC);
    localparam logic [DIG_W-1:0]          DIG_LAST   = DIG_W'(DECIMAL_DIGITS - 1);
    localparam logic [DIG_W-1:0]          DIG_DP     = DIG_W'(DP_POS);
    localparam logic [DECIMAL_DIGITS-1:0] ANODE_ONE  = {{(DECIMAL_DIGITS-1){1'b0}}, 1'b1};

    // Reset synchroniser state.
    logic                  r_rst_meta;
    logic                  r_rst_n;

    // Scan counters.
    logic [PRESC_W-1:0]    r_presc;
    logic [DIG_W-1:0]      r_digit;

    // Word capture.
    logic [BCD_W-1:0]      r_pending;
    logic                  r_pend_valid;
    logic [BCD_W-1:0]      r_shown;

    // Combinational helpers.
    logic                      w_slot_end;
    logic                      w_wrap;
    logic                      w_drive;
    logic                      w_run_zero;
    logic [DECIMAL_DIGITS-1:0] w_lz_blank;
    logic                      w_invalid;
    logic [3:0]                w_cur_digit;
    logic                      w_cur_blank;
    logic [6:0]                w_seg;

    // Reset asserts asynchronously everywhere but releases on a clock edge.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_rst_meta <= 1'b0;
            r_rst_n    <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_n    <= r_rst_meta;
        end
    end

    assign w_slot_end = (r_presc == PRESC_LAST);
    assign w_wrap     = w_slot_end && (r_digit == DIG_LAST);

    // Prescaler sets the slot length; the digit index steps on every slot end.
    always_ff @(posedge i_Clock or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_presc <= '0;
            r_digit <= '0;
        end else if (w_slot_end) begin
            r_presc <= '0;
            r_digit <= w_wrap ? '0 : r_digit + DIG_W'(1);
        end else begin
            r_presc <= r_presc + PRESC_W'(1);
        end
    end

    // Capture into pending at any time; promote to shown only at frame wrap.
    // A strobe landing on the wrap edge still lets the older pending word go
    // out first and keeps the new one queued for the following frame.
    always_ff @(posedge i_Clock or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_pending    <= '0;
            r_pend_valid <= 1'b0;
            r_shown      <= '0;
        end else begin
            // NOTE: non-blocking assignments let r_shown take the old
            // r_pending even when r_pending is rewritten on the same edge.
            if (w_wrap && r_pend_valid) begin
                r_shown <= r_pending;
            end
            if (i_DV) begin
                r_pending    <= i_BCD;
                r_pend_valid <= 1'b1;
            end else if (w_wrap) begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    // Leading-zero mask, scanned from the MSD down: a digit above the decimal
    // point blanks only while it and every digit above it are zero.
    always_comb begin
        // NOTE: defaults before the loop keep every bit assigned on all
        // paths, so no latch is inferred.
        w_lz_blank = '0;
        w_run_zero = 1'b1;
        for (int k = DECIMAL_DIGITS - 1; k >= 0; k--) begin
            w_run_zero = w_run_zero && (r_shown[4*k +: 4] == 4'd0);
            if (k > DP_POS) begin
                w_lz_blank[k] = w_run_zero;
            end
        end
    end

    // Any non-decimal nibble in the shown word marks the whole word invalid.
    always_comb begin
        w_invalid = 1'b0;
        for (int k = 0; k < DECIMAL_DIGITS; k++) begin
            w_invalid = w_invalid | is_bad_digit(r_shown[4*k +: 4]);
        end
    end

    assign w_cur_digit = r_shown[{r_digit, 2'b00} +: 4];
    assign w_cur_blank = w_lz_blank[r_digit];
    assign w_drive     = i_Enable && (r_presc >= PRESC_LIT);

    seg7_decode u_seg7_decode (
        .i_Digit   (w_cur_digit),
        .i_Blank   (w_cur_blank),
        .o_Segment (w_seg)
    );

    // Registered panel drive: everything off during the slot's dark window
    // or while disabled, otherwise one anode low with its digit pattern.
    always_ff @(posedge i_Clock or negedge r_rst_n) begin
        if (!r_rst_n) begin
            o_Anode   <= '1;
            o_Segment <= SEG_BLANK;
            o_DP      <= 1'b1;
            o_Invalid <= 1'b0;
            o_Frame   <= 1'b0;
        end else begin
            o_Frame   <= w_wrap;
            o_Invalid <= w_invalid;
            if (w_drive) begin
                o_Anode   <= ~(ANODE_ONE << r_digit);
                o_Segment <= w_seg;
                o_DP      <= (r_digit != DIG_DP);
            end else begin
                o_Anode   <= '1;
                o_Segment <= SEG_BLANK;
                o_DP      <= 1'b1;
            end
        end
    end

endmodule
